// File: rtl/wb_scoreboard_pkg.sv
// Shared types and defaults for the writeback scoreboard slice.
// Register indices are 5 bits; register 0 is hardwired zero.
package wb_scoreboard_pkg;

  localparam int NREG_DEF   = 32;
  localparam int CNT_W_DEF  = 2;
  localparam int STAT_W_DEF = 16;
  localparam int DATA_W     = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_scoreboard_sb_counter_bank.sv
// Pending-write counters for registers 1..NREG-1, with read ports for the
// issuing instruction's rs/rt/rd and the retiring writeback register.
module sb_counter_bank
  import wb_scoreboard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREG-1:1]  inc,
  input  logic [NREG-1:1]  dec,
  input  reg_idx_t         rs_idx,
  input  reg_idx_t         rt_idx,
  input  reg_idx_t         rd_idx,
  input  reg_idx_t         wb_idx,
  output logic [CNT_W-1:0] rs_cnt,
  output logic [CNT_W-1:0] rt_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  logic [CNT_W-1:0] cnt_q [NREG];

  // A retire against an empty counter is ignored here; the top flags it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (inc[r] && !(dec[r] && cnt_q[r] != '0))
          cnt_q[r] <= cnt_q[r] + 1'b1;
        else if (!inc[r] && dec[r] && cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  assign rs_cnt = cnt_q[rs_idx];
  assign rt_cnt = cnt_q[rt_idx];
  assign rd_cnt = cnt_q[rd_idx];
  assign wb_cnt = cnt_q[wb_idx];

endmodule

// File: rtl/wb_scoreboard.sv
// Issue-side register scoreboard: stalls ID on pending writes, bypasses the
// retiring writeback value to rs/rt, and keeps error/stall statistics.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  reg_idx_t          issue_rs,
  input  reg_idx_t          issue_rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              issue_regwrite,
  input  reg_idx_t          issue_rd,
  input  logic              wb_RegWrite,
  input  reg_idx_t          wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              issue_fire,
  output logic              fwd_rs,
  output logic              fwd_rt,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic              sb_error,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic wb_hit(input reg_idx_t r);
    return wb_RegWrite && (wb_write_reg == r) && (r != REG_ZERO);
  endfunction

  logic [NREG-1:1]  inc_v;
  logic [NREG-1:1]  dec_v;
  logic [CNT_W-1:0] rs_cnt, rt_cnt, rd_cnt, wb_cnt;
  logic             hazard_rs, hazard_rt, overflow;
  logic             sb_error_q;
  logic [STAT_W-1:0] stall_cycles_q;

  sb_counter_bank #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .inc    (inc_v),
    .dec    (dec_v),
    .rs_idx (issue_rs),
    .rt_idx (issue_rt),
    .rd_idx (issue_rd),
    .wb_idx (wb_write_reg),
    .rs_cnt (rs_cnt),
    .rt_cnt (rt_cnt),
    .rd_cnt (rd_cnt),
    .wb_cnt (wb_cnt)
  );

  // A single pending write that retires this cycle is bypassed; a count of
  // two or more means a younger write is still in flight, so hold the stall.
  assign hazard_rs = use_rs && (issue_rs != REG_ZERO) && (rs_cnt != '0) &&
                     !((rs_cnt == CNT_ONE) && wb_hit(issue_rs));
  assign hazard_rt = use_rt && (issue_rt != REG_ZERO) && (rt_cnt != '0) &&
                     !((rt_cnt == CNT_ONE) && wb_hit(issue_rt));
  assign overflow  = issue_regwrite && (issue_rd != REG_ZERO) &&
                     (rd_cnt == CNT_MAX) && !wb_hit(issue_rd);

  assign stall      = issue_valid && (hazard_rs || hazard_rt || overflow);
  assign issue_fire = issue_valid && !stall;

  assign fwd_rs = use_rs && (issue_rs != REG_ZERO) && (rs_cnt == CNT_ONE) && wb_hit(issue_rs);
  assign fwd_rt = use_rt && (issue_rt != REG_ZERO) && (rt_cnt == CNT_ONE) && wb_hit(issue_rt);
  assign fwd_rs_data = fwd_rs ? wb_data : '0;
  assign fwd_rt_data = fwd_rt ? wb_data : '0;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_v[r] = issue_fire && issue_regwrite && (issue_rd == reg_idx_t'(r));
      dec_v[r] = wb_RegWrite && (wb_write_reg == reg_idx_t'(r));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_error_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      if (wb_hit(wb_write_reg) && (wb_cnt == '0)) sb_error_q <= 1'b1;
      if (stall) stall_cycles_q <= sat_inc(stall_cycles_q);
    end
  end

  assign sb_error     = sb_error_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Consumer end of the writeback-forward interface: issue-side register scoreboard for the MIPS pipeline.
- Tracks in-flight register writes per architectural register: increments at ID issue, decrements when the registered writeback triple (RegWrite_out, write_reg_out, write_back_data_out) retires a write.
- Drives the ID-stage stall and a same-cycle writeback bypass of rs/rt operands.
- Sits between decode/issue and the register-file read port.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2^CNT_W-1 (3).
- STAT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  ID stage presents an instruction this cycle
- issue_rs  input  5  source register A
- issue_rt  input  5  source register B
- use_rs  input  1  instruction reads rs
- use_rt  input  1  instruction reads rt
- issue_regwrite  input  1  instruction will write issue_rd
- issue_rd  input  5  destination register
- wb_RegWrite  input  1  writeback retires a register write this cycle
- wb_write_reg  input  5  writeback destination
- wb_data  input  32  writeback value
- stall  output  1  hold ID/IF this cycle; instruction is not issued
- issue_fire  output  1  issue_valid && !stall
- fwd_rs  output  1  rs operand must come from wb_data
- fwd_rt  output  1  rt operand must come from wb_data
- fwd_rs_data  output  32  wb_data when fwd_rs, else 0
- fwd_rt_data  output  32  wb_data when fwd_rt, else 0
- sb_error  output  1  sticky: writeback retired a register with count 0
- stall_cycles  output  STAT_W  saturating count of stalled cycles

Behaviour:
- State: cnt[1..NREG-1] (CNT_W bits each), sb_error, stall_cycles.
- All state is cleared asynchronously on reset; outputs derived from state read 0 during reset.
- cnt[0] is constant 0. Issue or writeback targeting register 0 never alters state and never flags an error.
- wb_hit(r) = wb_RegWrite && wb_write_reg==r && r!=0.
- Source hazard(s) = use_s && s!=0 && cnt[s]!=0 && !(cnt[s]==1 && wb_hit(s)).
- fwd_s = use_s && s!=0 && cnt[s]==1 && wb_hit(s). This is combinational; the operand is valid in the same cycle.
- cnt[s]>=2 with a wb_hit means a younger write is still pending, so the bypass is not used and the stall is held.
- Overflow hazard = issue_regwrite && issue_rd!=0 && cnt[rd]==max && !wb_hit(rd).
- stall = issue_valid && (hazard(rs) || hazard(rt) || overflow). It is combinational, zero latency.
- Counter update on the clock edge, per register r:
  - inc = issue_fire && issue_regwrite && issue_rd==r
  - dec = wb_hit(r) && cnt[r]!=0
  - inc&&dec: hold
  - inc only: +1
  - dec only: -1
- Underflow: wb_hit(r) with cnt[r]==0 leaves the count at 0 and sets sb_error, which holds until reset.
- An instruction with rd==rs may issue in the cycle its rs is bypassed. The new pending write counts from the next edge.
- stall_cycles increments on each cycle with stall==1 and saturates at all-ones.
- Reset mid-operation clears all pending counts. Writebacks of pre-reset instructions then hit count 0 and set sb_error; the pipeline must be reset together.
- Latency: stall and fwd are combinational with issue inputs. Count changes are visible one cycle after issue_fire or writeback.

Decomposition:
- Shared package:
  - REG_ZERO=5'd0
  - CNT_W, NREG defaults
  - the reg_idx_t typedef for 5-bit register indices, if the pipeline adopts one
- One sub-module, sb_counter_bank: NREG-1 counters with inc/dec vectors and a per-register count read for rs, rt and rd.
- Hazard/forward logic and statistics stay in the top module.

Test Plan:
- Reset, then issue rs=3 rt=4 with no pending -> stall=0, fwd_rs=fwd_rt=0, issue_fire=1.
- Issue write r5, next cycle issue use_rs=1 rs=5 with no writeback -> stall=1, stall_cycles=1. Next cycle wb_RegWrite=1 wb_write_reg=5 wb_data=32'hDEADBEEF -> stall=0, fwd_rs=1, fwd_rs_data=32'hDEADBEEF; cnt[5] returns to 0.
- Three issues writing r7 with no writeback -> cnt[7]=3. A fourth writing r7 -> stall=1. Same cycle with wb_hit(7) -> stall=0, cnt[7] stays 3.
- Two pending writes to r9, wb_hit(9), reader rs=9 -> fwd_rs=0, stall=1, cnt[9]=1.
- Issue writing r0, then read r0 -> no count change, stall=0, fwd=0. Writeback to r0 -> sb_error stays 0.
- Writeback to r12 with cnt[12]=0 -> sb_error=1, held until reset. Assert reset mid-stream with pending counts -> all counts 0 and stall=0 immediately (asynchronous).
